// File: rtl/expr_eval_pipe.sv
// rtl/expr_eval_pipe.sv - multi-lane expression evaluator behind an elastic valid/ready pipeline
//
// Purpose: evaluates one op (shared by all lanes) over LANES independent W-bit
// operand pairs, in signed or unsigned mode, at the moment a transaction is
// accepted. Results and per-lane flags travel through DEPTH register stages
// that load whenever they are empty or their content moves on the same cycle.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  input handshake; in_ready may depend on out_ready
//   op, sgn             operation select and signed mode, captured per transaction
//   a, b                packed operands, lane 0 in the LSBs
//   out_valid, out_ready output handshake
//   y, div0, ovf        packed results and per-lane flags, stable while stalled
//   txn_cnt             count of output handshakes, wraps at 16 bits
module expr_eval_pipe #(
    parameter int W     = 6,
    parameter int LANES = 3,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic               sgn,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] y,
    output logic [LANES-1:0]   div0,
    output logic [LANES-1:0]   ovf,
    output logic [15:0]        txn_cnt
);

    localparam int YW = LANES * W;

    // Returns {div0, ovf, y} for a single lane.
    function automatic logic [W+1:0] eval_lane(
        input logic [3:0]   f_op,
        input logic         f_sgn,
        input logic [W-1:0] fa,
        input logic [W-1:0] fb
    );
        logic [W-1:0]   r;
        logic           f_ovf;
        logic           f_div0;
        logic [W:0]     wide;
        logic [2*W-1:0] prod;
        logic [W-1:0]   mag_a;
        logic [W-1:0]   mag_b;
        logic [W-1:0]   mag_q;
        logic           big_shift;
        r         = '0;
        f_ovf     = 1'b0;
        f_div0    = 1'b0;
        wide      = '0;
        prod      = '0;
        mag_a     = '0;
        mag_b     = '0;
        mag_q     = '0;
        big_shift = (32'(fb) >= 32'(W));
        case (f_op)
            4'd0: begin
                wide  = {1'b0, fa} + {1'b0, fb};
                r     = wide[W-1:0];
                f_ovf = f_sgn ? ((fa[W-1] == fb[W-1]) && (r[W-1] != fa[W-1])) : wide[W];
            end
            4'd1: begin
                // The extra top bit of the widened difference is the unsigned borrow.
                wide  = {1'b0, fa} - {1'b0, fb};
                r     = wide[W-1:0];
                f_ovf = f_sgn ? ((fa[W-1] != fb[W-1]) && (r[W-1] != fa[W-1])) : wide[W];
            end
            4'd2: r = fa & fb;
            4'd3: r = fa ^ fb;
            4'd4: r = fa | fb;
            4'd5: r = big_shift ? '0 : (fa << fb);
            4'd6: begin
                if (big_shift)
                    r = (f_sgn && fa[W-1]) ? '1 : '0;
                else if (f_sgn)
                    r = $unsigned($signed(fa) >>> fb);
                else
                    r = fa >> fb;
            end
            4'd7: r = {{(W-1){1'b0}}, (f_sgn ? ($signed(fa) < $signed(fb)) : (fa < fb))};
            4'd8: r = {{(W-1){1'b0}}, (fa == fb)};
            4'd9: begin
                if (f_sgn)
                    prod = $unsigned($signed({{W{fa[W-1]}}, fa}) * $signed({{W{fb[W-1]}}, fb}));
                else
                    prod = {{W{1'b0}}, fa} * {{W{1'b0}}, fb};
                r     = prod[W-1:0];
                f_ovf = f_sgn ? (prod[2*W-1:W] != {W{r[W-1]}}) : (prod[2*W-1:W] != '0);
            end
            4'd10: begin
                if (fb == '0) begin
                    f_div0 = 1'b1;
                end else if (f_sgn && (fa == {1'b1, {(W-1){1'b0}}}) && (fb == '1)) begin
                    r     = fa;
                    f_ovf = 1'b1;
                end else begin
                    // Divide magnitudes, then restore the sign; this truncates toward zero.
                    mag_a = (f_sgn && fa[W-1]) ? -fa : fa;
                    mag_b = (f_sgn && fb[W-1]) ? -fb : fb;
                    mag_q = mag_a / mag_b;
                    r     = (f_sgn && (fa[W-1] ^ fb[W-1])) ? -mag_q : mag_q;
                end
            end
            4'd11: r = {{(W-1){1'b0}}, ^fa};
            4'd12: r = (fa != '0) ? fb : ~fb;
            default: r = '0;
        endcase
        return {f_div0, f_ovf, r};
    endfunction

    logic [YW-1:0]    res_y;
    logic [LANES-1:0] res_div0;
    logic [LANES-1:0] res_ovf;
    logic [W+1:0]     lane_r;

    always_comb begin
        res_y    = '0;
        res_div0 = '0;
        res_ovf  = '0;
        lane_r   = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_r            = eval_lane(op, sgn, a[l*W +: W], b[l*W +: W]);
            res_y[l*W +: W]   = lane_r[W-1:0];
            res_ovf[l]        = lane_r[W];
            res_div0[l]       = lane_r[W+1];
        end
    end

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [YW-1:0]    y_q    [DEPTH];
    logic [YW-1:0]    y_d    [DEPTH];
    logic [LANES-1:0] div0_q [DEPTH];
    logic [LANES-1:0] div0_d [DEPTH];
    logic [LANES-1:0] ovf_q  [DEPTH];
    logic [LANES-1:0] ovf_d  [DEPTH];
    logic [15:0]      txn_cnt_q, txn_cnt_d;

    logic [DEPTH-1:0] stage_rdy;
    logic [DEPTH-1:0] src_vld;
    logic [YW-1:0]    src_y    [DEPTH];
    logic [LANES-1:0] src_div0 [DEPTH];
    logic [LANES-1:0] src_ovf  [DEPTH];
    logic             full_tail;

    // A stage can load unless it and every stage after it are full while the
    // output is stalled; computed per stage without a rippling self-reference.
    always_comb begin
        stage_rdy = '0;
        full_tail = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            full_tail = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
                full_tail = full_tail & vld_q[j];
            end
            stage_rdy[i] = !full_tail || out_ready;
        end
    end

    always_comb begin
        src_vld     = '0;
        src_vld[0]  = in_valid;
        src_y[0]    = res_y;
        src_div0[0] = res_div0;
        src_ovf[0]  = res_ovf;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i]  = vld_q[i-1];
            src_y[i]    = y_q[i-1];
            src_div0[i] = div0_q[i-1];
            src_ovf[i]  = ovf_q[i-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            y_d[i]    = y_q[i];
            div0_d[i] = div0_q[i];
            ovf_d[i]  = ovf_q[i];
            if (stage_rdy[i]) begin
                vld_d[i] = src_vld[i];
                if (src_vld[i]) begin
                    y_d[i]    = src_y[i];
                    div0_d[i] = src_div0[i];
                    ovf_d[i]  = src_ovf[i];
                end
            end
        end
        txn_cnt_d = txn_cnt_q;
        if (vld_q[DEPTH-1] && out_ready)
            txn_cnt_d = txn_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= '0;
            txn_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                y_q[i]    <= '0;
                div0_q[i] <= '0;
                ovf_q[i]  <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            txn_cnt_q <= txn_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                y_q[i]    <= y_d[i];
                div0_q[i] <= div0_d[i];
                ovf_q[i]  <= ovf_d[i];
            end
        end
    end

    assign in_ready  = stage_rdy[0];
    assign out_valid = vld_q[DEPTH-1];
    assign y         = y_q[DEPTH-1];
    assign div0      = div0_q[DEPTH-1];
    assign ovf       = ovf_q[DEPTH-1];
    assign txn_cnt   = txn_cnt_q;

endmodule
